// File: rtl/u_mask_pkg.sv
// Shared types for the masked nearest-match scanner.
package u_mask_pkg;

   // Controller states: waiting for a request, walking chunks, holding a result
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   // Scan direction; encoded so that the raw i_lsb request bit casts straight in
   typedef enum logic {
      DIR_MSB = 1'b0,
      DIR_LSB = 1'b1
   } dir_t;

   // Index width that stays at least one bit wide for single-entry ranges
   function automatic int idxWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/u_mask_chunk.sv
// Combinational finder for the in-range matching bit nearest the pivot side
// of one C-bit chunk. The bound is the last valid bit on the pivot side:
// in LSB mode bits [bound:0] are eligible and the highest hit wins,
// in MSB mode bits [C-1:bound] are eligible and the lowest hit wins.
module u_mask_chunk
   import u_mask_pkg::*;
#(
   parameter int C  = 8,
   parameter int CW = idxWidth(C)
)
(
   input  logic [C-1:0]  i_bits,
   input  logic          i_match_bit,
   input  dir_t          i_dir,
   input  logic [CW-1:0] i_bound,
   output logic          o_hit,
   output logic [CW-1:0] o_idx
);

   // Priority walk toward the pivot so the last qualifying bit seen is the nearest one
   always_comb begin
      o_hit = 1'b0;
      o_idx = '0;
      if (i_dir == DIR_LSB) begin
         for (int i = 0; i < C; i++) begin
            if ((i <= int'(i_bound)) && (i_bits[i] == i_match_bit)) begin
               o_hit = 1'b1;
               o_idx = CW'(i);
            end
         end
      end else begin
         for (int i = C - 1; i >= 0; i--) begin
            if ((i >= int'(i_bound)) && (i_bits[i] == i_match_bit)) begin
               o_hit = 1'b1;
               o_idx = CW'(i);
            end
         end
      end
   end

endmodule

// File: rtl/u_mask_scan.sv
// Multi-cycle scanner: finds the bit equal to i_match_bit nearest a pivot,
// walking one C-bit chunk per cycle away from the pivot.
module u_mask_scan
   import u_mask_pkg::*;
#(
   parameter int W = 32,
   parameter int C = 8
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_vld,
   output logic                 o_rdy,
   input  logic [W-1:0]         i_x,
   input  logic [$clog2(W)-1:0] i_pivot,
   input  logic                 i_match_bit,
   input  logic                 i_lsb,
   output logic                 o_vld,
   input  logic                 i_rdy,
   output logic                 o_match,
   output logic [$clog2(W)-1:0] o_pos
);

   localparam int IW = $clog2(W);
   localparam int N  = W / C;
   localparam int NW = idxWidth(N);
   localparam int CW = idxWidth(C);

   state_t          r_state;
   state_t          w_stateNext;
   logic [W-1:0]    r_x;
   logic [IW-1:0]   r_pivot;
   logic            r_matchBit;
   dir_t            r_dir;
   logic [NW-1:0]   r_chunkIdx;
   logic            r_match;
   logic [IW-1:0]   r_pos;

   logic            w_accept;
   logic [C-1:0]    w_chunks [N];
   logic [C-1:0]    w_chunkBits;
   logic [NW-1:0]   w_pivotChunk;
   logic [CW-1:0]   w_localPivot;
   logic [CW-1:0]   w_bound;
   logic            w_hit;
   logic [CW-1:0]   w_localIdx;
   logic [IW-1:0]   w_hitPos;
   logic            w_lastChunk;
   logic            w_pivotBad;

   assign o_rdy    = (r_state == IDLE);
   assign o_vld    = (r_state == DONE);
   assign o_match  = r_match;
   assign o_pos    = r_pos;
   assign w_accept = i_vld && (r_state == IDLE);

   for (genvar g = 0; g < N; g++) begin : g_chunk
      assign w_chunks[g] = r_x[g*C +: C];
   end

   assign w_chunkBits  = w_chunks[r_chunkIdx];
   assign w_pivotChunk = NW'(int'(r_pivot) / C);
   assign w_localPivot = CW'(int'(r_pivot) % C);
   assign w_pivotBad   = (int'(r_pivot) >= W);

   // Only the pivot's own chunk is partially masked; chunks further out are fully in range
   assign w_bound = (r_chunkIdx == w_pivotChunk) ? w_localPivot :
                    (r_dir == DIR_LSB)           ? CW'(C - 1)   : '0;

   assign w_lastChunk = (r_dir == DIR_LSB) ? (r_chunkIdx == '0)
                                           : (r_chunkIdx == NW'(N - 1));

   assign w_hitPos = IW'(int'(r_chunkIdx) * C + int'(w_localIdx));

   u_mask_chunk #(
      .C  (C),
      .CW (CW)
   ) u_chunk (
      .i_bits      (w_chunkBits),
      .i_match_bit (r_matchBit),
      .i_dir       (r_dir),
      .i_bound     (w_bound),
      .o_hit       (w_hit),
      .o_idx       (w_localIdx)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next-state: scan ends on a hit, at the far chunk, or immediately for an out-of-range pivot
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE:    if (i_vld) w_stateNext = SCAN;
         SCAN:    if (w_pivotBad || w_hit || w_lastChunk) w_stateNext = DONE;
         DONE:    if (i_rdy) w_stateNext = IDLE;
         default: w_stateNext = IDLE;
      endcase
   end

   // Request capture, chunk stepping and result registration
   always_ff @(posedge clk) begin
      if (rst) begin
         r_x        <= '0;
         r_pivot    <= '0;
         r_matchBit <= 1'b0;
         r_dir      <= DIR_MSB;
         r_chunkIdx <= '0;
         r_match    <= 1'b0;
         r_pos      <= '0;
      end else if (w_accept) begin
         r_x        <= i_x;
         r_pivot    <= i_pivot;
         r_matchBit <= i_match_bit;
         r_dir      <= dir_t'(i_lsb);
         r_chunkIdx <= NW'(int'(i_pivot) / C);
      end else if (r_state == SCAN) begin
         if (w_pivotBad) begin
            r_match <= 1'b0;
            r_pos   <= '0;
         end else if (w_hit) begin
            r_match <= 1'b1;
            r_pos   <= w_hitPos;
         end else if (w_lastChunk) begin
            r_match <= 1'b0;
            r_pos   <= '0;
         end else if (r_dir == DIR_LSB) begin
            r_chunkIdx <= r_chunkIdx - NW'(1);
         end else begin
            r_chunkIdx <= r_chunkIdx + NW'(1);
         end
      end
   end

endmodule

// File: tb/tb_u_mask_scan.sv
// Self-checking bench for u_mask_scan: directed table, multi-cycle corner
// sequences and randomized requests against a bit-by-bit reference walk.
module tb_u_mask_scan;

   localparam int W  = 32;
   localparam int C  = 8;
   localparam int IW = 5;
   localparam int N  = W / C;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_vld;
   logic          o_rdy;
   logic [W-1:0]  i_x;
   logic [IW-1:0] i_pivot;
   logic          i_match_bit;
   logic          i_lsb;
   logic          o_vld;
   logic          i_rdy;
   logic          o_match;
   logic [IW-1:0] o_pos;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0]  x;
      logic [IW-1:0] pivot;
      logic          m;
      logic          lsb;
      logic          eMatch;
      logic [IW-1:0] ePos;
      int            eLat;
   } vec_t;

   vec_t vecs [12];

   u_mask_scan #(.W(W), .C(C)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_vld       (i_vld),
      .o_rdy       (o_rdy),
      .i_x         (i_x),
      .i_pivot     (i_pivot),
      .i_match_bit (i_match_bit),
      .i_lsb       (i_lsb),
      .o_vld       (o_vld),
      .i_rdy       (i_rdy),
      .o_match     (o_match),
      .o_pos       (o_pos)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Absolute time limit so a stuck design can never hang the run
   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   // Reference: walk bit positions outward from the pivot; latency is the chunk span covered
   task automatic refModel(input logic [W-1:0] x, input int pivot, input logic m, input logic lsb,
                           output logic eMatch, output logic [IW-1:0] ePos, output int eLat);
      int found;
      found  = -1;
      if (lsb) begin
         for (int p = pivot; p >= 0; p--) if (found < 0 && x[p] == m) found = p;
         eLat = (found >= 0) ? (pivot / C - found / C + 1) : (pivot / C + 1);
      end else begin
         for (int p = pivot; p < W; p++) if (found < 0 && x[p] == m) found = p;
         eLat = (found >= 0) ? (found / C - pivot / C + 1) : (N - pivot / C);
      end
      eMatch = (found >= 0);
      ePos   = (found >= 0) ? IW'(found) : '0;
   endtask

   // Present one request, let it be accepted, then scramble the request inputs
   task automatic applyStimulus(input logic [W-1:0] x, input logic [IW-1:0] pivot, input logic m, input logic lsb);
      @(negedge clk);
      checkOutput("rdy_before_accept", o_rdy, 1);
      i_vld       = 1'b1;
      i_x         = x;
      i_pivot     = pivot;
      i_match_bit = m;
      i_lsb       = lsb;
      @(posedge clk);
      @(negedge clk);
      i_vld       = 1'b0;
      i_x         = $urandom;
      i_pivot     = IW'($urandom);
      i_match_bit = 1'($urandom);
      i_lsb       = 1'($urandom);
   endtask

   task automatic waitResult(output int lat);
      lat = 0;
      while (lat < 64) begin
         @(posedge clk);
         #1;
         lat++;
         if (o_vld) break;
      end
      if (!o_vld) checkOutput("vld_timeout", o_vld, 1);
   endtask

   task automatic releaseResult();
      @(negedge clk);
      i_rdy = 1'b1;
      @(posedge clk);
      #1;
      i_rdy = 1'b0;
      checkOutput("vld_after_ack", o_vld, 0);
      checkOutput("rdy_after_ack", o_rdy, 1);
   endtask

   task automatic runAndCheck(input string tag, input logic [W-1:0] x, input logic [IW-1:0] pivot,
                              input logic m, input logic lsb, input logic eMatch,
                              input logic [IW-1:0] ePos, input int eLat, input int holdCycles);
      int lat;
      applyStimulus(x, pivot, m, lsb);
      waitResult(lat);
      checkOutput({tag, "_match"}, o_match, eMatch);
      checkOutput({tag, "_pos"}, o_pos, ePos);
      checkOutput({tag, "_latency"}, lat, eLat);
      for (int h = 0; h < holdCycles; h++) begin
         @(posedge clk);
         #1;
         checkOutput({tag, "_hold_vld"}, o_vld, 1);
         checkOutput({tag, "_hold_match"}, o_match, eMatch);
         checkOutput({tag, "_hold_pos"}, o_pos, ePos);
         checkOutput({tag, "_hold_rdy"}, o_rdy, 0);
      end
      releaseResult();
   endtask

   initial begin
      logic          eMatch;
      logic [IW-1:0] ePos;
      int            eLat;
      logic [W-1:0]  rx;
      logic [IW-1:0] rp;
      logic          rm;
      logic          rl;

      vecs[0]  = '{32'h0000_0100, 5'd20, 1'b1, 1'b1, 1'b1, 5'd8,  2};
      vecs[1]  = '{32'hFFFF_FFFF, 5'd3,  1'b0, 1'b0, 1'b0, 5'd0,  4};
      vecs[2]  = '{32'h0000_0010, 5'd4,  1'b1, 1'b1, 1'b1, 5'd4,  1};
      vecs[3]  = '{32'h7FFF_FFFF, 5'd31, 1'b1, 1'b0, 1'b0, 5'd0,  1};
      vecs[4]  = '{32'h8000_0000, 5'd0,  1'b1, 1'b0, 1'b1, 5'd31, 4};
      vecs[5]  = '{32'h0000_0001, 5'd31, 1'b1, 1'b1, 1'b1, 5'd0,  4};
      vecs[6]  = '{32'hFFFF_FFFE, 5'd0,  1'b1, 1'b1, 1'b0, 5'd0,  1};
      vecs[7]  = '{32'h00F0_0000, 5'd10, 1'b1, 1'b0, 1'b1, 5'd20, 2};
      vecs[8]  = '{32'h0000_0810, 5'd12, 1'b1, 1'b1, 1'b1, 5'd11, 1};
      vecs[9]  = '{32'h0000_2000, 5'd12, 1'b1, 1'b1, 1'b0, 5'd0,  2};
      vecs[10] = '{32'hFFFF_DFFF, 5'd12, 1'b0, 1'b0, 1'b1, 5'd13, 1};
      vecs[11] = '{32'h0000_0000, 5'd7,  1'b0, 1'b0, 1'b1, 5'd7,  1};

      rst         = 1'b1;
      i_vld       = 1'b0;
      i_rdy       = 1'b0;
      i_x         = '0;
      i_pivot     = '0;
      i_match_bit = 1'b0;
      i_lsb       = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_rdy", o_rdy, 1);
      checkOutput("reset_vld", o_vld, 0);
      checkOutput("reset_match", o_match, 0);
      checkOutput("reset_pos", o_pos, 0);
      rst = 1'b0;

      $display("[TB] directed table");
      for (int v = 0; v < 12; v++) begin
         runAndCheck($sformatf("vec%0d", v), vecs[v].x, vecs[v].pivot, vecs[v].m, vecs[v].lsb,
                     vecs[v].eMatch, vecs[v].ePos, vecs[v].eLat, 0);
      end

      $display("[TB] backpressure");
      runAndCheck("bp", 32'h0000_0100, 5'd20, 1'b1, 1'b1, 1'b1, 5'd8, 2, 5);

      $display("[TB] reset during scan");
      applyStimulus(32'hFFFF_FFFF, 5'd3, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midrst_vld", o_vld, 0);
      checkOutput("midrst_rdy", o_rdy, 1);
      checkOutput("midrst_match", o_match, 0);
      checkOutput("midrst_pos", o_pos, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("midrst_no_result", o_vld, 0);
      runAndCheck("post_rst", 32'h0000_0100, 5'd20, 1'b1, 1'b1, 1'b1, 5'd8, 2, 0);

      $display("[TB] randomized requests");
      for (int t = 0; t < 80; t++) begin
         case ($urandom_range(0, 3))
            0:       rx = $urandom;
            1:       rx = $urandom & $urandom & $urandom & $urandom;
            2:       rx = $urandom | $urandom | $urandom | $urandom;
            default: rx = ($urandom_range(0, 1) == 1) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
         endcase
         rp = IW'($urandom_range(0, W - 1));
         rm = 1'($urandom);
         rl = 1'($urandom);
         refModel(rx, int'(rp), rm, rl, eMatch, ePos, eLat);
         runAndCheck($sformatf("rand%0d", t), rx, rp, rm, rl, eMatch, ePos, eLat, $urandom_range(0, 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
